flit_mux2: RTL and testbench
============================

Name: flit_mux2

Overview:
- Registered 2:1 flit multiplexer for the NoC router output stage.
- Steers one of two input ports (data, valid, virtual channel) to a single output port under a one-hot select vector.
- Used standalone for per-block energy characterisation, so idle toggling is minimised.

Parameters:
- DATA_W, 22, flit data width in bits.
- VCH_W, 2, virtual-channel ID width in bits.
- PORT_W, 5, select vector width; one bit per router port; only bits 0 and 1 are used here.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- idata_0  in  DATA_W  port 0 flit data.
- ivalid_0  in  1  port 0 flit valid.
- ivch_0  in  VCH_W  port 0 virtual channel.
- idata_1  in  DATA_W  port 1 flit data.
- ivalid_1  in  1  port 1 flit valid.
- ivch_1  in  VCH_W  port 1 virtual channel.
- sel  in  PORT_W  one-hot port select; bit0 = port 0, bit1 = port 1.
- odata  out  DATA_W  selected flit data, registered.
- ovalid  out  1  selected valid, registered.
- ovch  out  VCH_W  selected virtual channel, registered.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_).
- While rst_=0: odata=0, ovalid=0, ovch=0, applied immediately without waiting for a clock edge.
- Latency is 1 cycle. Inputs and sel sampled on a rising edge appear on the outputs after that edge.
- Legal select values:
  - sel == 'b01: port 0 is routed.
  - sel == 'b10: port 1 is routed.
  - Routing copies idata, ivalid and ivch of the chosen port.
- Illegal select: sel == 0, both bits 0 and 1 set, or any bit >= 2 set.
  - Next cycle: ovalid=0, ovch=0, odata=0.
  - No priority resolution is performed.
- No handshake and no backpressure. The flit is forwarded whenever the select is legal; ivalid=0 is forwarded as ovalid=0.
- With a legal sel and ivalid=0, odata still follows the selected idata, unless the optional feature is enabled.
- The unselected port has no effect on any output.
- sel may change every cycle. The change takes effect at the next edge, with no bubble cycle.
- Reset deasserting mid-stream: the first edge after release samples the inputs normally.

Optional Feature:
- Macro: FLIT_MUX_DATA_HOLD_EN.
- Defined:
  - The odata register loads only when the select is legal and the selected ivalid=1. Otherwise it holds its previous value, which cuts idle toggling.
  - ovalid and ovch behave as in the base behaviour.
- Undefined: odata follows the base behaviour.

Decomposition:
- Shared package (noc_pkg) holds:
  - DATA_W, VCH_W, PORT_W defaults.
  - Flit type codes: TYPE_NONE, TYPE_HEAD, TYPE_DATA, TYPE_TAIL.
  - Port index constants: PORT0=0, PORT1=1.
- One small sub-module is natural: flit_mux_sel_decode. It checks the one-hot select and outputs pick0, pick1 and sel_ok.
- All registers live in the top.

Test Plan:
- Reset: rst_=0 with ivalid_1=1, idata_1=22'h3FFFFF, sel='b10 -> outputs all 0 with no clock edge; after release, next edge gives odata=22'h3FFFFF, ovalid=1.
- Port 1 stream: sel='b10, idata_1 walks 22'h000000, 22'h3FC000, 22'h3FFFC0, 22'h0FFFFF, one per cycle, with ivalid_1=1 and ivch_1=2 -> odata shows the same sequence one cycle later, ovalid=1, ovch=2; port 0 toggling has no effect.
- Port 0 select: sel='b01, idata_0=22'h000009, ivalid_0=1, ivch_0=1 -> next cycle odata=22'h000009, ovalid=1, ovch=1.
- Illegal select: sel=0, then sel='b11, then sel='b100, with both ports valid -> ovalid=0, odata=0, ovch=0 on each following cycle.
- Switch and idle: sel toggles 'b01 -> 'b10 on consecutive cycles -> outputs alternate ports with no gap. Then ivalid_1=0 with idata_1=22'h00000F:
  - Macro undefined: ovalid=0, odata=22'h00000F.
  - Macro defined: ovalid=0, odata holds the previous valid flit.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default widths, flit type codes and
// port index constants used by the output-stage muxes.
package noc_pkg;

  localparam int DEF_DATA_W = 22;
  localparam int DEF_VCH_W  = 2;
  localparam int DEF_PORT_W = 5;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_DATA = 2'd2,
    TYPE_TAIL = 2'd3
  } flit_type_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  function automatic logic [DEF_PORT_W-1:0] port_bit(input int idx);
    logic [DEF_PORT_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/flit_mux_sel_decode.sv
// One-hot select checker for the 2:1 flit mux.
// Anything other than exactly port 0 or exactly port 1 is rejected.
module flit_mux_sel_decode
  import noc_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W
) (
  input  logic [PORT_W-1:0] sel,
  output logic              pick0,
  output logic              pick1,
  output logic              sel_ok
);

  localparam logic [PORT_W-1:0] SEL0 =
    PORT_W'(port_bit(PORT0));
  localparam logic [PORT_W-1:0] SEL1 =
    PORT_W'(port_bit(PORT1));

  assign pick0  = (sel == SEL0);
  assign pick1  = (sel == SEL1);
  assign sel_ok = pick0 | pick1;

endmodule

// File: rtl/flit_mux2.sv
// Registered 2:1 flit mux for the router output stage.
// Optional macro FLIT_MUX_DATA_HOLD_EN: odata loads only on a valid flit.
module flit_mux2
  import noc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int VCH_W  = DEF_VCH_W,
  parameter int PORT_W = DEF_PORT_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [PORT_W-1:0] sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);

  logic              pick0;
  logic              pick1;
  logic              sel_ok;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_valid;
  logic [VCH_W-1:0]  nxt_vch;

  flit_mux_sel_decode #(
    .PORT_W (PORT_W)
  ) u_dec (
    .sel    (sel),
    .pick0  (pick0),
    .pick1  (pick1),
    .sel_ok (sel_ok)
  );

  always_comb begin
    nxt_data  = '0;
    nxt_valid = 1'b0;
    nxt_vch   = '0;
    if (sel_ok) begin
      unique case (1'b1)
        pick0: begin
          nxt_data  = idata_0;
          nxt_valid = ivalid_0;
          nxt_vch   = ivch_0;
        end
        pick1: begin
          nxt_data  = idata_1;
          nxt_valid = ivalid_1;
          nxt_vch   = ivch_1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      ovalid <= nxt_valid;
      ovch   <= nxt_vch;
`ifdef FLIT_MUX_DATA_HOLD_EN
      // nxt_valid already implies a legal select
      if (nxt_valid) odata <= nxt_data;
`else
      odata  <= nxt_data;
`endif
    end
  end

endmodule

// File: tb/tb_flit_mux2.sv
// Scoreboard bench for flit_mux2: directed plan plus random traffic.
// Expected flits come from a port-array model of the routing rules.
module tb_flit_mux2;

  typedef struct packed {
    logic [21:0] d;
    logic        v;
    logic [1:0]  c;
  } exp_t;

  logic        clk;
  logic        rst_;
  logic [21:0] idata_0;
  logic        ivalid_0;
  logic [1:0]  ivch_0;
  logic [21:0] idata_1;
  logic        ivalid_1;
  logic [1:0]  ivch_1;
  logic [4:0]  sel;
  logic [21:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;

  int total = 0;
  int bad   = 0;

  exp_t  q[$];
  string qn[$];
  logic [21:0] last_d;

  flit_mux2 dut (
    .clk      (clk),
    .rst_     (rst_),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic cmp(string nm, exp_t e);
    total++;
    if (odata !== e.d || ovalid !== e.v || ovch !== e.c) begin
      bad++;
      $display("FAIL %s got d=%h v=%b c=%h want d=%h v=%b c=%h",
               nm, odata, ovalid, ovch, e.d, e.v, e.c);
    end
  endtask

  // Monitor: one expectation retires per registered output cycle
  always @(negedge clk) begin
    if (rst_ && q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = qn.pop_front();
      cmp(n, e);
    end
  end

  function automatic exp_t model(logic [4:0] s);
    logic [21:0] dd[2];
    logic        vv[2];
    logic [1:0]  cc[2];
    bit          legal;
    int          idx;
    exp_t        e;
    dd[0] = idata_0; vv[0] = ivalid_0; cc[0] = ivch_0;
    dd[1] = idata_1; vv[1] = ivalid_1; cc[1] = ivch_1;
    legal = ($countones(s) == 1) && (s[4:2] == 3'b000);
    idx   = s[1] ? 1 : 0;
    e.v = legal && vv[idx];
    e.c = legal ? cc[idx] : 2'd0;
`ifdef FLIT_MUX_DATA_HOLD_EN
    if (e.v) last_d = dd[idx];
    e.d = last_d;
`else
    e.d = legal ? dd[idx] : 22'd0;
`endif
    return e;
  endfunction

  task automatic step(string nm, logic [4:0] s,
                      logic [21:0] d0, logic v0, logic [1:0] c0,
                      logic [21:0] d1, logic v1, logic [1:0] c1);
    exp_t e;
    sel = s;
    idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
    idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
    @(posedge clk);
    e = model(s);
    q.push_back(e);
    qn.push_back(nm);
    #1;
  endtask

  function automatic logic [21:0] rd();
    return 22'($urandom);
  endfunction

  initial begin
    logic [21:0] walk[4];
    logic [4:0]  rs;
    exp_t        z;
    int          k;
    z = '0;
    last_d = '0;
    walk[0] = 22'h000000; walk[1] = 22'h3FC000;
    walk[2] = 22'h3FFFC0; walk[3] = 22'h0FFFFF;

    rst_ = 1'b0;
    sel = 5'b00010;
    idata_0 = '0; ivalid_0 = 1'b0; ivch_0 = '0;
    idata_1 = 22'h3FFFFF; ivalid_1 = 1'b1; ivch_1 = 2'd3;
    #3;
    cmp("reset_hold", z);
    #1 rst_ = 1'b1;
    step("reset_release", 5'b00010, rd(), 1'b1, 2'd0,
         22'h3FFFFF, 1'b1, 2'd3);

    foreach (walk[i])
      step("p1_stream", 5'b00010, rd(), 1'($urandom),
           2'($urandom), walk[i], 1'b1, 2'd2);

    step("p0_select", 5'b00001, 22'h000009, 1'b1, 2'd1,
         rd(), 1'b1, 2'd3);

    step("illegal_0", 5'b00000, rd(), 1'b1, 2'd1, rd(), 1'b1, 2'd2);
    step("illegal_11", 5'b00011, rd(), 1'b1, 2'd1, rd(), 1'b1, 2'd2);
    step("illegal_100", 5'b00100, rd(), 1'b1, 2'd1, rd(), 1'b1, 2'd2);
    step("illegal_10000", 5'b10000, rd(), 1'b1, 2'd3, rd(), 1'b1, 2'd2);

    for (int i = 0; i < 4; i++)
      step("switch", (i % 2 == 0) ? 5'b00001 : 5'b00010,
           rd(), 1'b1, 2'd1, rd(), 1'b1, 2'd2);
    step("idle_p1", 5'b00010, rd(), 1'b1, 2'd1,
         22'h00000F, 1'b0, 2'd2);
    step("idle_p0", 5'b00001, 22'h0000AA, 1'b0, 2'd3,
         rd(), 1'b1, 2'd2);

    step("pre_areset", 5'b00001, 22'h2ABCDE, 1'b1, 2'd3,
         rd(), 1'b0, 2'd0);
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1 cmp("async_reset", z);
    last_d = '0;
    @(posedge clk);
    #1 rst_ = 1'b1;
    step("post_release", 5'b00010, rd(), 1'b1, 2'd0,
         22'h155555, 1'b1, 2'd1);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      rs = 5'b00001;
      else if (k < 8) rs = 5'b00010;
      else            rs = 5'($urandom);
      step("random", rs, rd(), 1'($urandom), 2'($urandom),
           rd(), 1'($urandom), 2'($urandom));
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
